multicycle_control: RTL and testbench

//  Multi-cycle Moore control FSM that sequences the existing processor datapath.
//  It replaces single-cycle control and adds an instruction-register load strobe.
//  It adds a Mem_Req/Mem_Ack handshake so data memory can be shared or slow.

---
 rtl/charis_pkg.sv | 50 +++++
 rtl/instr_class_dec.sv | 28 ++
 rtl/multicycle_control.sv | 146 ++++++++++++++
 tb/tb_multicycle_control.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/charis_pkg.sv
// Shared opcodes, ALU codes, FSM state encoding and instruction classes for the
// multi-cycle control unit.
package charis_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_NANDI = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_NAND = 4'b0101;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_DEC  = 3'd1,
        S_EXEC = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CL_RTYPE, CL_IMM, CL_LUI, CL_LI, CL_BR, CL_BEQ, CL_BNE,
        CL_LB, CL_LW, CL_SW, CL_ILLEGAL
    } iclass_t;

    // ALU operation driven from EXEC onward; immediates share one class so the
    // opcode picks between add/nand/or.
    function automatic logic [3:0] exec_alu_func(iclass_t cls, logic [5:0] op, logic [3:0] func);
        logic [3:0] f;
        f = ALU_ADD;
        case (cls)
            CL_RTYPE:       f = func;
            CL_IMM:         f = (op == OP_NANDI) ? ALU_NAND : (op == OP_ORI) ? ALU_OR : ALU_ADD;
            CL_BEQ, CL_BNE: f = ALU_SUB;
            default:        f = ALU_ADD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_class_dec.sv
// Combinational opcode to instruction-class decode.
module instr_class_dec
    import charis_pkg::*;
(
    input  logic [5:0] opcode,
    output iclass_t    cls
);

    always_comb begin
        cls = CL_ILLEGAL;
        case (opcode)
            OP_RTYPE: cls = CL_RTYPE;
            OP_ADDI,
            OP_NANDI,
            OP_ORI:   cls = CL_IMM;
            OP_LUI:   cls = CL_LUI;
            OP_LI:    cls = CL_LI;
            OP_B:     cls = CL_BR;
            OP_BEQ:   cls = CL_BEQ;
            OP_BNE:   cls = CL_BNE;
            OP_LB:    cls = CL_LB;
            OP_LW:    cls = CL_LW;
            OP_SW:    cls = CL_SW;
            default:  cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle Moore control FSM (IF/DEC/EXEC/MEM/WB) with a Mem_Req/Mem_Ack
// handshake and a sticky bus-error flag on memory timeout.
module multicycle_control
    import charis_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        Mem_Ack,
    output logic        PC_Sel,
    output logic        PC_LdEn,
    output logic        IR_LdEn,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic        Mem_Req,
    output logic        Mem_WrEn,
    output logic        lb_MEM_trim,
    output logic        Bus_Err,
    output logic [2:0]  State
);

    state_t              state, next_state;
    iclass_t             cls;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                aborted;
    logic                bus_err;
    logic                timeout;
    logic                is_mem, is_br, imm_b, b_sel;
    logic [3:0]          alu_f;
    logic                unused_instr_bits;

    assign unused_instr_bits = ^Instr[25:4];

    instr_class_dec u_dec (
        .opcode (Instr[31:26]),
        .cls    (cls)
    );

    assign is_mem  = (cls == CL_LB) || (cls == CL_LW) || (cls == CL_SW);
    assign is_br   = (cls == CL_BR) || (cls == CL_BEQ) || (cls == CL_BNE);
    assign b_sel   = (cls == CL_BEQ) || (cls == CL_BNE) || (cls == CL_SW);
    assign imm_b   = (cls == CL_IMM) || (cls == CL_LI) || (cls == CL_LUI) || is_mem;
    assign alu_f   = exec_alu_func(cls, Instr[31:26], Instr[3:0]);
    assign timeout = (state == S_MEM) && !Mem_Ack && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= S_IF;
            wait_cnt <= '0;
            aborted  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_EXEC)
                wait_cnt <= '0;
            else if (state == S_MEM && !Mem_Ack)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            // aborted only suppresses the WB write of this instruction; bus_err is sticky
            if (timeout) begin
                bus_err <= 1'b1;
                aborted <= 1'b1;
            end else if (state == S_IF) begin
                aborted <= 1'b0;
            end
        end
    end

    always_comb begin
        next_state    = state;
        PC_Sel        = 1'b0;
        PC_LdEn       = 1'b0;
        IR_LdEn       = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = 4'b0000;
        Mem_Req       = 1'b0;
        Mem_WrEn      = 1'b0;
        lb_MEM_trim   = 1'b0;
        // Reset gates the strobes so a pending memory request drops immediately
        if (Reset) begin
            case (state)
                S_IF: begin
                    IR_LdEn    = 1'b1;
                    next_state = S_DEC;
                end
                S_DEC: begin
                    RF_B_sel   = b_sel;
                    next_state = (cls == CL_ILLEGAL) ? S_WB : S_EXEC;
                end
                S_EXEC: begin
                    RF_B_sel    = b_sel;
                    ALU_Bin_sel = imm_b;
                    ALU_func    = alu_f;
                    if (is_br) begin
                        PC_LdEn    = 1'b1;
                        PC_Sel     = (cls == CL_BR) ? 1'b1 : (cls == CL_BEQ) ? Zero : ~Zero;
                        next_state = S_IF;
                    end else begin
                        next_state = is_mem ? S_MEM : S_WB;
                    end
                end
                S_MEM: begin
                    RF_B_sel    = b_sel;
                    ALU_Bin_sel = imm_b;
                    ALU_func    = alu_f;
                    Mem_Req     = 1'b1;
                    Mem_WrEn    = (cls == CL_SW);
                    lb_MEM_trim = (cls == CL_LB);
                    if (Mem_Ack) begin
                        if (cls == CL_SW) begin
                            PC_LdEn    = 1'b1;
                            next_state = S_IF;
                        end else begin
                            next_state = S_WB;
                        end
                    end else if (timeout) begin
                        next_state = S_WB;
                    end
                end
                S_WB: begin
                    RF_B_sel      = b_sel;
                    ALU_Bin_sel   = imm_b;
                    ALU_func      = alu_f;
                    PC_LdEn       = 1'b1;
                    RF_WrEn       = !aborted && (cls != CL_ILLEGAL) && (cls != CL_SW);
                    RF_WrData_sel = (cls == CL_LB) || (cls == CL_LW);
                    next_state    = S_IF;
                end
                default: next_state = S_IF;
            endcase
        end
    end

    assign Bus_Err = bus_err;
    assign State   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// the FSM and compares outputs against hand-derived values.
module tb_multicycle_control;

    logic        Clk, Reset, Zero, Mem_Ack;
    logic [31:0] Instr;
    logic        PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        Mem_Req, Mem_WrEn, lb_MEM_trim, Bus_Err;
    logic [2:0]  State;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0, pcld_cnt = 0, rfwr_cnt = 0;
    int req_base, pcld_base, rfwr_base;

    localparam logic [31:0] I_ADD   = {6'b100000, 26'd0};
    localparam logic [31:0] I_NANDI = {6'b110010, 26'd0};
    localparam logic [31:0] I_BEQ   = {6'b000000, 26'd0};
    localparam logic [31:0] I_BNE   = {6'b000001, 26'd0};
    localparam logic [31:0] I_B     = {6'b111111, 26'd0};
    localparam logic [31:0] I_LW    = {6'b001111, 26'd0};
    localparam logic [31:0] I_LB    = {6'b000011, 26'd0};
    localparam logic [31:0] I_SW    = {6'b011111, 26'd0};
    localparam logic [31:0] I_BAD   = {6'b101010, 26'd0};

    multicycle_control dut (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .Mem_Ack(Mem_Ack),
        .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .IR_LdEn(IR_LdEn), .RF_WrEn(RF_WrEn),
        .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
        .ALU_func(ALU_func), .Mem_Req(Mem_Req), .Mem_WrEn(Mem_WrEn),
        .lb_MEM_trim(lb_MEM_trim), .Bus_Err(Bus_Err), .State(State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (Mem_Req) req_cnt++;
        if (PC_LdEn) pcld_cnt++;
        if (RF_WrEn) rfwr_cnt++;
    end

    function automatic logic [17:0] all_outs();
        return {PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
                ALU_func, Mem_Req, Mem_WrEn, lb_MEM_trim, Bus_Err, State};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic snap();
        req_base  = req_cnt;
        pcld_base = pcld_cnt;
        rfwr_base = rfwr_cnt;
    endtask

    initial begin
        Reset = 1'b0; Instr = I_ADD; Zero = 1'b0; Mem_Ack = 1'b0;
        #3;
        chk("reset_outs_async", 32'(all_outs()), 32'd0);
        step();
        chk("reset_outs_clk", 32'(all_outs()), 32'd0);
        Reset = 1'b1;
        #1;
        chk("rel_state_if", State, 0);
        chk("rel_ir_ld", IR_LdEn, 1);

        // R-type add: IF, DEC, EXEC, WB
        snap();
        step(); chk("add_dec", State, 1);
        chk("add_dec_rfwr", RF_WrEn, 0);
        step(); chk("add_exec", State, 2);
        chk("add_exec_alu", ALU_func, 4'b0000);
        chk("add_exec_bin", ALU_Bin_sel, 0);
        step(); chk("add_wb", State, 4);
        chk("add_wb_rfwr", RF_WrEn, 1);
        chk("add_wb_pcsel", PC_Sel, 0);
        chk("add_wb_wdsel", RF_WrData_sel, 0);
        step(); chk("add_back_if", State, 0);
        chk("add_pcld_once", pcld_cnt - pcld_base, 1);
        chk("add_rfwr_once", rfwr_cnt - rfwr_base, 1);

        // nandi with a stray Mem_Ack outside MEM
        Instr = I_NANDI; Mem_Ack = 1'b1;
        step(); step(); chk("nandi_exec", State, 2);
        chk("nandi_alu", ALU_func, 4'b0101);
        chk("nandi_bin", ALU_Bin_sel, 1);
        step(); chk("nandi_wb", State, 4);
        chk("nandi_wb_alu_hold", ALU_func, 4'b0101);
        chk("nandi_wb_rfwr", RF_WrEn, 1);
        chk("nandi_no_req", Mem_Req, 0);
        Mem_Ack = 1'b0;
        step();

        // beq taken: 3 cycles
        Instr = I_BEQ; Zero = 1'b1;
        step(); chk("beq_dec_bsel", RF_B_sel, 1);
        step(); chk("beq_exec", State, 2);
        chk("beq_pcsel", PC_Sel, 1);
        chk("beq_pcld", PC_LdEn, 1);
        chk("beq_alu", ALU_func, 4'b0001);
        step(); chk("beq_back_if", State, 0);

        // bne with Zero=1: not taken
        Instr = I_BNE;
        step(); step(); chk("bne_pcsel", PC_Sel, 0);
        chk("bne_pcld", PC_LdEn, 1);
        step();

        // unconditional b ignores Zero
        Instr = I_B; Zero = 1'b0;
        step(); step(); chk("b_pcsel", PC_Sel, 1);
        step(); chk("b_back_if", State, 0);

        // lw with Mem_Ack after 3 wait cycles: 8 cycles total
        Instr = I_LW; snap();
        step(); step(); chk("lw_exec_bin", ALU_Bin_sel, 1);
        step(); chk("lw_mem1", State, 3);
        chk("lw_mem_wr", Mem_WrEn, 0);
        step(); chk("lw_mem2", State, 3);
        step(); chk("lw_mem3", State, 3);
        step(); chk("lw_mem4", State, 3);
        Mem_Ack = 1'b1;
        step(); Mem_Ack = 1'b0;
        chk("lw_wb", State, 4);
        chk("lw_wb_rfwr", RF_WrEn, 1);
        chk("lw_wb_wdsel", RF_WrData_sel, 1);
        chk("lw_wb_bin", ALU_Bin_sel, 1);
        step(); chk("lw_back_if", State, 0);
        chk("lw_req_cycles", req_cnt - req_base, 4);

        // lb with Mem_Ack already high: single MEM cycle
        Instr = I_LB;
        step(); step(); step();
        chk("lb_mem", State, 3);
        chk("lb_trim", lb_MEM_trim, 1);
        Mem_Ack = 1'b1;
        step(); Mem_Ack = 1'b0;
        chk("lb_wb", State, 4);
        chk("lb_wb_wdsel", RF_WrData_sel, 1);
        step();

        // sw with no Mem_Ack: times out after 15 MEM cycles
        Instr = I_SW; snap();
        step(); step(); step();
        for (int i = 0; i < 15; i++) begin
            chk("sw_mem_state", State, 3);
            chk("sw_mem_wr", Mem_WrEn, 1);
            chk("sw_no_err_yet", Bus_Err, 0);
            step();
        end
        chk("sw_to_wb", State, 4);
        chk("sw_bus_err", Bus_Err, 1);
        chk("sw_wb_rfwr", RF_WrEn, 0);
        chk("sw_wb_pcld", PC_LdEn, 1);
        step(); chk("sw_back_if", State, 0);
        chk("sw_err_sticky", Bus_Err, 1);
        chk("sw_req_cycles", req_cnt - req_base, 15);
        chk("sw_no_rfwr", rfwr_cnt - rfwr_base, 0);

        // reset asserted mid-MEM of lw
        Instr = I_LW;
        step(); step(); step();
        chk("rst_lw_in_mem", Mem_Req, 1);
        #2 Reset = 1'b0;
        #1 chk("rst_mid_outs", 32'(all_outs()), 32'd0);
        #2 Reset = 1'b1;
        #1 chk("rst_rel_if", State, 0);
        chk("rst_rel_buserr", Bus_Err, 0);

        // illegal opcode: DEC -> WB, no write, PC+4
        Instr = I_BAD; snap();
        step(); chk("bad_dec", State, 1);
        step(); chk("bad_wb", State, 4);
        chk("bad_pcsel", PC_Sel, 0);
        step(); chk("bad_back_if", State, 0);
        chk("bad_pcld_once", pcld_cnt - pcld_base, 1);
        chk("bad_no_rfwr", rfwr_cnt - rfwr_base, 0);
        chk("bad_no_req", req_cnt - req_base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
